// File: rtl/rmii_frame_tx.sv
// RMII transmit framer: preamble/SFD, client payload dibits, optional
// CRC-32 FCS, then inter-frame gap. One dibit per 50 MHz clk_in cycle.
//
// Ports:
//   clk_in, rst_in (async, active-low)
//   trigger_in      : start request, taken only while ready_out=1
//   data_in[1:0]    : payload dibit, presented the cycle after data_ready_out
//   last_dibit_in   : marks data_in as the final payload dibit
//   ready_out       : idle, trigger_in will be accepted
//   data_ready_out  : client must drive the next dibit in the following cycle
//   err_out         : one-cycle pulse, payload truncated at MAX_PAYLOAD_DIBITS
//   axiov / axiod   : PHY TXEN / TXD
//
// Build option: define RMII_FRAME_TX_FCS_EN to append the CRC-32 FCS.
// Without it the frame is preamble + payload only.

module rmii_frame_tx #(
    parameter int IFG_DIBITS         = 48,
    parameter int MAX_PAYLOAD_DIBITS = 6000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       trigger_in,
    input  logic [1:0] data_in,
    input  logic       last_dibit_in,
    output logic       ready_out,
    output logic       data_ready_out,
    output logic       err_out,
    output logic       axiov,
    output logic [1:0] axiod
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_PAY,
        S_FCS,
        S_GAP
    } state_t;

    localparam logic [14:0] PRE_DR   = 15'd29;
    localparam logic [14:0] PRE_SFD  = 15'd30;
    localparam logic [14:0] FCS_LAST = 15'd15;
    localparam logic [14:0] IFG_LAST = 15'(IFG_DIBITS - 1);
    localparam logic [14:0] MAX_CNT  = 15'(MAX_PAYLOAD_DIBITS);

    state_t      state_q, state_d;
    logic [14:0] cnt_q, cnt_d;
    logic        ready_q, ready_d;
    logic        dr_q, dr_d;
    logic        take_q, take_d;
    logic        err_q, err_d;
    logic        txen_q, txen_d;
    logic [1:0]  txd_q, txd_d;
    logic        is_last;

`ifdef RMII_FRAME_TX_FCS_EN
    logic [31:0] crc_q, crc_d;

    // Reflected CRC-32, data bit 0 first.
    function automatic logic [31:0] crc2(input logic [31:0] c,
                                         input logic [1:0]  d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) crc_q <= '1;
        else         crc_q <= crc_d;
    end
`endif

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            dr_q    <= 1'b0;
            take_q  <= 1'b0;
            err_q   <= 1'b0;
            txen_q  <= 1'b0;
            txd_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            dr_q    <= dr_d;
            take_q  <= take_d;
            err_q   <= err_d;
            txen_q  <= txen_d;
            txd_q   <= txd_d;
        end
    end

    // Output registers lead the wire by one cycle: each state computes
    // what the pins show in the next cycle. take_q marks a cycle whose
    // data_in is valid because data_ready_out was high in the one before.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 15'd1;
        ready_d = 1'b0;
        dr_d    = dr_q;
        take_d  = dr_q;
        err_d   = 1'b0;
        txen_d  = txen_q;
        txd_d   = txd_q;
        is_last = last_dibit_in || (cnt_q + 15'd1 == MAX_CNT);
`ifdef RMII_FRAME_TX_FCS_EN
        crc_d   = crc_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                ready_d = 1'b1;
                dr_d    = 1'b0;
                txen_d  = 1'b0;
                txd_d   = 2'b00;
                if (trigger_in && ready_q) begin
                    state_d = S_PRE;
                    ready_d = 1'b0;
                    txen_d  = 1'b1;
                    txd_d   = 2'b01;
`ifdef RMII_FRAME_TX_FCS_EN
                    crc_d   = '1;
`endif
                end
            end
            S_PRE: begin
                txd_d = 2'b01;
                if (cnt_q == PRE_DR) dr_d = 1'b1;
                if (cnt_q == PRE_SFD) begin
                    txd_d   = 2'b11;
                    state_d = S_PAY;
                    cnt_d   = '0;
                end
            end
            S_PAY: begin
                cnt_d = cnt_q;
                if (take_q) begin
                    cnt_d = cnt_q + 15'd1;
                    txd_d = data_in;
`ifdef RMII_FRAME_TX_FCS_EN
                    crc_d = crc2(crc_q, data_in);
`endif
                    if (is_last) begin
                        err_d = !last_dibit_in;
                        dr_d  = 1'b0;
                        cnt_d = '0;
`ifdef RMII_FRAME_TX_FCS_EN
                        state_d = S_FCS;
`else
                        state_d = S_GAP;
`endif
                    end
                end
            end
`ifdef RMII_FRAME_TX_FCS_EN
            S_FCS: begin
                // Shift the CRC out LSB first, inverted.
                txd_d = ~crc_q[1:0];
                crc_d = {2'b00, crc_q[31:2]};
                if (cnt_q == FCS_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end
            end
`endif
            S_GAP: begin
                txen_d = 1'b0;
                txd_d  = 2'b00;
                if (cnt_q == IFG_LAST) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                txen_d  = 1'b0;
                txd_d   = 2'b00;
            end
        endcase
    end

    assign ready_out      = ready_q;
    assign data_ready_out = dr_q;
    assign err_out        = err_q;
    assign axiov          = txen_q;
    assign axiod          = txd_q;

endmodule

// File: doc/rmii_frame_tx.md
Name: rmii_frame_tx

Overview:
RMII transmit framer sitting directly downstream of the frame/row exporter and directly upstream of the Ethernet PHY pins.
- On a trigger, emits preamble+SFD, then streams 2-bit payload dibits pulled from the client via a ready/data handshake.
- Appends the Ethernet FCS (CRC-32), then enforces the inter-frame gap before accepting the next trigger.
- One dibit per clk_in cycle (50 MHz RMII reference clock).

Parameters:
IFG_DIBITS, 48, inter-frame gap length in cycles (12 bytes).
MAX_PAYLOAD_DIBITS, 6000, payload cap (1500 bytes); reaching it forces frame end.

Ports:
clk_in  input  1  RMII reference clock; all logic on rising edge
rst_in  input  1  asynchronous, active-low reset
trigger_in  input  1  start-frame request; honoured only when ready_out=1
data_in  input  2  payload dibit, LSB-first byte order
last_dibit_in  input  1  marks data_in as final payload dibit
ready_out  output  1  idle and able to accept trigger_in
data_ready_out  output  1  client must present the next dibit on the following cycle
err_out  output  1  one-cycle pulse: payload truncated at MAX_PAYLOAD_DIBITS
axiov  output  1  PHY TXEN
axiod  output  2  PHY TXD

Behaviour:
- Reset (rst_in=0, asynchronous):
  - axiov=0, axiod=0, data_ready_out=0, err_out=0, ready_out=0, state=IDLE.
  - ready_out=1 from the first clock after reset release.
  - Mid-frame reset aborts the frame immediately, with no FCS and no IFG.
- All outputs are registered.
- States: IDLE -> PREAMBLE -> PAYLOAD -> FCS -> GAP -> IDLE.
- IDLE:
  - ready_out=1, axiov=0.
  - trigger_in=1 sampled at the edge ending cycle T0 -> PREAMBLE, ready_out=0 from T1.
  - trigger_in in any other state is ignored.
- PREAMBLE:
  - Cycles T1..T32, axiov=1.
  - axiod = 2'b01 for 31 cycles, then 2'b11 at T32 (0x55 x7, 0xD5, LSB-first).
  - data_ready_out rises in T31.
- PAYLOAD:
  - The block samples data_in/last_dibit_in at the end of every cycle from T32 onward, while data_ready_out was high in the preceding cycle.
  - Dibit sampled at the end of cycle k appears on axiod in cycle k+1, so axiov is continuous from the SFD into the payload.
  - CRC is updated with every sampled dibit.
  - When last_dibit_in=1 is sampled: data_ready_out drops next cycle; the next state is FCS.
  - Any further client data is ignored.
  - If the sampled-dibit count reaches MAX_PAYLOAD_DIBITS without last_dibit_in: that dibit is treated as last, and err_out pulses for one cycle.
  - last_dibit_in is ignored outside sampling cycles.
- CRC-32:
  - Reflected polynomial 0xEDB88320, init 0xFFFFFFFF, 2 bits per cycle, data bit 0 first.
  - FCS = ~CRC.
- FCS state:
  - 16 cycles, axiov=1, axiod = FCS bits [1:0], [3:2], ..., [31:30].
  - Byte order is LSB byte first.
- GAP:
  - axiov=0, axiod=0 for IFG_DIBITS cycles, ready_out=0.
  - Then IDLE, with ready_out=1 in the following cycle.
- Counter:
  - One shared 15-bit counter.
  - Cleared on every state transition.
  - Never wraps within a state, because the limits are below 2^15.
- A zero-length payload is impossible: at least one dibit is always sampled. There is no padding to 64 bytes; the client is responsible for minimum length.

Optional Feature:
Macro: RMII_FRAME_TX_FCS_EN
- Defined: CRC logic and the FCS state are present, as above.
- Undefined:
  - CRC logic is removed; PAYLOAD goes directly to GAP.
  - Frame = preamble + payload only, for links where the receiver ignores FCS.
  - All other timing is unchanged.

Test Plan:
1. Reset then idle -> ready_out=1 on first clock after release; axiov=0, data_ready_out=0, err_out=0.
2. Trigger with payload ASCII "123456789" (36 dibits, last on 36th):
   - axiov high for exactly 84 contiguous cycles: 31x01, 11, payload, FCS.
   - FCS bytes on wire: 0x26 0x39 0xF4 0xCB.
   - Then 48 idle cycles; ready_out=1 after.
3. Client streams 6001 dibits with no last_dibit_in -> exactly 6000 payload dibits sent; err_out high one cycle; FCS covers 6000 dibits; 6001st ignored.
4. trigger_in held high continuously -> back-to-back frames separated by exactly 48 axiov=0 cycles; no triggers accepted during PREAMBLE/PAYLOAD/FCS/GAP.
5. rst_in low during payload dibit 10 -> axiov=0 asynchronously (same cycle); after release ready_out=1 and the next frame is correct, with no stale CRC.
6. RMII_FRAME_TX_FCS_EN undefined, 4-dibit payload -> axiov high exactly 36 cycles, then 48-cycle gap.
